// File: rtl/fill_ram.sv
// AXI4 write master that erases one RAM bank by streaming a fixed fill pattern
// in full-size INCR bursts, with a bounded number of bursts awaiting response.
module fill_ram #(
    parameter logic [63:0] BASE_ADDR       = 64'h0,
    parameter logic [63:0] BANK_SIZE       = 64'h4_0000_0000,
    parameter int          DW              = 512,
    parameter int          BURST_LEN       = 64,
    parameter int          MAX_OUTSTANDING = 8,
    parameter logic [31:0] FILL_PATTERN    = 32'hFFFF_FFFF
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            erase,
    output logic            idle,
    output logic            error,
    output logic [63:0]     M_AXI_AWADDR,
    output logic [7:0]      M_AXI_AWLEN,
    output logic [2:0]      M_AXI_AWSIZE,
    output logic [1:0]      M_AXI_AWBURST,
    output logic            M_AXI_AWVALID,
    input  logic            M_AXI_AWREADY,
    output logic [DW-1:0]   M_AXI_WDATA,
    output logic [DW/8-1:0] M_AXI_WSTRB,
    output logic            M_AXI_WLAST,
    output logic            M_AXI_WVALID,
    input  logic            M_AXI_WREADY,
    input  logic [1:0]      M_AXI_BRESP,
    input  logic            M_AXI_BVALID,
    output logic            M_AXI_BREADY
);
    localparam logic [63:0] BURST_BYTES = 64'(BURST_LEN) * 64'(DW / 8);
    localparam logic [63:0] NBURSTS     = BANK_SIZE / BURST_BYTES;
    localparam int          CW          = $clog2(NBURSTS + 64'd1);
    localparam int          BW          = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int          OW          = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] NB        = CW'(NBURSTS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [OW-1:0] MAX_OS    = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] aw_cnt, w_burst_cnt, b_cnt, b_cnt_nxt;
    logic [BW-1:0] beat_cnt;
    logic [OW-1:0] outstanding;
    logic          aw_hs, w_hs, b_hs;

    // AWVALID cannot drop before AWREADY: outstanding only falls while it is
    // held and aw_cnt only moves on the handshake itself.
    assign M_AXI_AWVALID = (state == S_RUN) && (aw_cnt < NB) && (outstanding < MAX_OS);
    assign M_AXI_AWADDR  = BASE_ADDR + 64'(aw_cnt) * BURST_BYTES;
    assign M_AXI_AWLEN   = 8'(BURST_LEN - 1);
    assign M_AXI_AWSIZE  = 3'($clog2(DW / 8));
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_WVALID  = (state == S_RUN) && (w_burst_cnt < aw_cnt);
    assign M_AXI_WLAST   = M_AXI_WVALID && (beat_cnt == LAST_BEAT);
    assign M_AXI_WDATA   = {(DW / 32){FILL_PATTERN}};
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_BREADY  = (state != S_IDLE);
    assign idle          = (state == S_IDLE);

    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
    assign b_hs  = M_AXI_BVALID && M_AXI_BREADY;

    always_comb begin
        state_nxt = state;
        b_cnt_nxt = b_cnt + CW'(b_hs);
        case (state)
            S_IDLE: if (erase) state_nxt = S_RUN;
            // Jump straight to IDLE when the final response lands in RUN so
            // idle always rises the cycle after the last B handshake.
            S_RUN: begin
                if (aw_cnt == NB && w_burst_cnt == NB)
                    state_nxt = (b_cnt_nxt == NB) ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: if (b_cnt_nxt == NB) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_IDLE;
            aw_cnt      <= '0;
            w_burst_cnt <= '0;
            b_cnt       <= '0;
            beat_cnt    <= '0;
            outstanding <= '0;
            error       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE) begin
                if (erase) begin
                    aw_cnt      <= '0;
                    w_burst_cnt <= '0;
                    b_cnt       <= '0;
                    beat_cnt    <= '0;
                    outstanding <= '0;
                    error       <= 1'b0;
                end
            end else begin
                aw_cnt <= aw_cnt + CW'(aw_hs);
                b_cnt  <= b_cnt_nxt;
                if (w_hs) begin
                    if (beat_cnt == LAST_BEAT) begin
                        beat_cnt    <= '0;
                        w_burst_cnt <= w_burst_cnt + CW'(1);
                    end else begin
                        beat_cnt <= beat_cnt + BW'(1);
                    end
                end
                case ({aw_hs, b_hs})
                    2'b10:   outstanding <= outstanding + OW'(1);
                    2'b01:   outstanding <= outstanding - OW'(1);
                    default: outstanding <= outstanding;
                endcase
                if (b_hs && M_AXI_BRESP != 2'b00) error <= 1'b1;
            end
        end
    end
endmodule
